// File: rtl/mmap_router.sv
// Multi-region address decoder with a fixed-latency tagged read-return pipeline.
// Requests are routed to the lowest-index matching region, rebased to that region's start.
module mmap_router #(
  parameter int                   NREG     = 4,
  parameter int                   AW       = 16,
  parameter int                   DW       = 8,
  parameter logic [NREG*AW-1:0]   STARTS   = {16'hFF80, 16'hC000, 16'h8000, 16'h0000},
  parameter logic [NREG*AW-1:0]   ENDS     = {16'hFFFE, 16'hDFFF, 16'h9FFF, 16'h7FFF},
  parameter int                   RD_LAT   = 2,
  parameter int                   REQ_REG  = 1,
  parameter logic [DW-1:0]        OPEN_BUS = 8'hFF
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [AW-1:0]        m_address,
  input  logic [DW-1:0]        m_indata,
  input  logic                 m_load,
  input  logic                 m_store,
  output logic [DW-1:0]        m_outdata,
  output logic                 m_rvalid,
  output logic                 m_miss,
  output logic [7:0]           miss_count,
  output logic [NREG*AW-1:0]   s_address,
  output logic [NREG*DW-1:0]   s_indata,
  input  logic [NREG*DW-1:0]   s_outdata,
  output logic [NREG-1:0]      s_load,
  output logic [NREG-1:0]      s_store
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int D  = REQ_REG + RD_LAT;

  typedef struct packed {
    logic          valid;
    logic          mapped;
    logic [IW-1:0] idx;
  } tag_t;

  logic          hit_any;
  logic [IW-1:0] hit_idx;
  logic [AW-1:0] hit_off;

  // Offset-from-start compare is the same as START <= addr <= END given END >= START,
  // and it yields the rebased address for free. Descending scan lets index 0 win.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_off = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((m_address - STARTS[i*AW +: AW]) <= (ENDS[i*AW +: AW] - STARTS[i*AW +: AW])) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
        hit_off = m_address - STARTS[i*AW +: AW];
      end
    end
  end

  logic req_load;
  logic req_store;
  logic req_miss;

  // A simultaneous load and store is treated as a store only.
  assign req_store = m_store;
  assign req_load  = m_load & ~m_store;
  assign req_miss  = (m_load | m_store) & ~hit_any;

  logic [NREG*AW-1:0] nxt_address;
  logic [NREG*DW-1:0] nxt_indata;
  logic [NREG-1:0]    nxt_load;
  logic [NREG-1:0]    nxt_store;

  always_comb begin
    nxt_address = '0;
    nxt_indata  = '0;
    nxt_load    = '0;
    nxt_store   = '0;
    for (int i = 0; i < NREG; i++) begin
      if (hit_any && (hit_idx == IW'(i))) begin
        nxt_address[i*AW +: AW] = hit_off;
        nxt_indata[i*DW +: DW]  = m_indata;
        nxt_load[i]             = req_load;
        nxt_store[i]            = req_store;
      end
    end
  end

  generate
    if (REQ_REG != 0) begin : g_req_reg
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          s_address <= '0;
          s_indata  <= '0;
          s_load    <= '0;
          s_store   <= '0;
        end else begin
          s_address <= nxt_address;
          s_indata  <= nxt_indata;
          s_load    <= nxt_load;
          s_store   <= nxt_store;
        end
      end
    end else begin : g_req_comb
      // Gated by resetn so the slave side reads all-zero while reset is held.
      always_comb begin
        s_address = resetn ? nxt_address : '0;
        s_indata  = resetn ? nxt_indata  : '0;
        s_load    = resetn ? nxt_load    : '0;
        s_store   = resetn ? nxt_store   : '0;
      end
    end
  endgenerate

  tag_t tag_in;
  tag_t tag_q [D];
  tag_t tag_out;

  always_comb begin
    tag_in = '0;
    if (req_load) begin
      tag_in.valid  = 1'b1;
      tag_in.mapped = hit_any;
      tag_in.idx    = hit_idx;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < D; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < D; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[D-1];

  // Return side is a pure strobe with no backpressure: m_outdata is meaningful
  // only while m_rvalid is high and is forced to 0 otherwise.
  logic [DW-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (tag_out.idx == IW'(i)) rd_sel = s_outdata[i*DW +: DW];
    end
    m_rvalid  = tag_out.valid;
    m_outdata = '0;
    if (tag_out.valid) m_outdata = tag_out.mapped ? rd_sel : OPEN_BUS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_miss     <= 1'b0;
      miss_count <= 8'h00;
    end else begin
      m_miss <= req_miss;
      if (req_miss && (miss_count != 8'hFF)) miss_count <= miss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mmap_router.sv
// Directed bench for mmap_router: read returns are checked by a queue-based monitor,
// slave-side routing and miss accounting are checked directly after each request.
module tb_mmap_router;

  localparam int NREG = 4;
  localparam int AW   = 16;
  localparam int DW   = 8;

  logic                 clock  = 1'b0;
  logic                 resetn = 1'b0;
  logic [AW-1:0]        m_address = '0;
  logic [DW-1:0]        m_indata  = '0;
  logic                 m_load    = 1'b0;
  logic                 m_store   = 1'b0;
  logic [DW-1:0]        m_outdata;
  logic                 m_rvalid;
  logic                 m_miss;
  logic [7:0]           miss_count;
  logic [NREG*AW-1:0]   s_address;
  logic [NREG*DW-1:0]   s_indata;
  logic [NREG*DW-1:0]   s_outdata;
  logic [NREG-1:0]      s_load;
  logic [NREG-1:0]      s_store;

  logic [DW-1:0]        o_outdata;
  logic                 o_rvalid;
  logic                 o_miss;
  logic [7:0]           o_miss_count;
  logic [NREG*AW-1:0]   o_address;
  logic [NREG*DW-1:0]   o_indata;
  logic [NREG-1:0]      o_load;
  logic [NREG-1:0]      o_store;

  // Slave read data: R3=0x33, R2=0x22, R1=0x5A, R0=0x11
  assign s_outdata = 32'h33_22_5A_11;

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  mmap_router u_dut (
    .clock(clock), .resetn(resetn),
    .m_address(m_address), .m_indata(m_indata), .m_load(m_load), .m_store(m_store),
    .m_outdata(m_outdata), .m_rvalid(m_rvalid), .m_miss(m_miss), .miss_count(miss_count),
    .s_address(s_address), .s_indata(s_indata), .s_outdata(s_outdata),
    .s_load(s_load), .s_store(s_store)
  );

  mmap_router #(
    .STARTS({16'hFF80, 16'hC000, 16'h0000, 16'h0000})
  ) u_ovl (
    .clock(clock), .resetn(resetn),
    .m_address(m_address), .m_indata(m_indata), .m_load(m_load), .m_store(m_store),
    .m_outdata(o_outdata), .m_rvalid(o_rvalid), .m_miss(o_miss), .miss_count(o_miss_count),
    .s_address(o_address), .s_indata(o_indata), .s_outdata(s_outdata),
    .s_load(o_load), .s_store(o_store)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: one bus cycle; read returns expected 3 cycles after the request cycle
  task automatic req(input logic ld, input logic st, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic exp_rv, input logic [DW-1:0] exp_rd);
    m_load    = ld;
    m_store   = st;
    m_address = a;
    m_indata  = d;
    if (exp_rv) begin
      exp_q.push_back(exp_rd);
      exp_cyc_q.push_back(cyc + 3);
    end
    @(posedge clock);
    #1;
    m_load    = 1'b0;
    m_store   = 1'b0;
    m_address = '0;
    m_indata  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // monitor: pops the expected queue whenever a return is presented
  always @(negedge clock) begin
    logic [DW-1:0] e;
    int            ec;
    if (m_rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rvalid_unexpected got data %h expected no return (cycle %0d)", m_outdata, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rdata", {56'd0, m_outdata}, {56'd0, e});
        check("rcycle", 64'(cyc), 64'(ec));
      end
    end else begin
      check("rdata_idle", {56'd0, m_outdata}, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rvalid"}, {63'd0, m_rvalid}, 64'd0);
    check({tag, "_outdata"}, {56'd0, m_outdata}, 64'd0);
    check({tag, "_miss"}, {63'd0, m_miss}, 64'd0);
    check({tag, "_miss_count"}, {56'd0, miss_count}, 64'd0);
    check({tag, "_s_load"}, {60'd0, s_load}, 64'd0);
    check({tag, "_s_store"}, {60'd0, s_store}, 64'd0);
    check({tag, "_s_address"}, s_address, 64'd0);
    check({tag, "_s_indata"}, {32'd0, s_indata}, 64'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    idle(2);

    // single load to R1
    req(1'b1, 1'b0, 16'h8123, 8'h00, 1'b1, 8'h5A);
    @(negedge clock);
    check("t1_s_load", {60'd0, s_load}, 64'h2);
    check("t1_s_address", s_address, 64'h0000_0000_0123_0000);
    check("t1_miss", {63'd0, m_miss}, 64'd0);
    idle(4);

    // back-to-back loads across regions
    req(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 8'h11);
    req(1'b1, 1'b0, 16'hC005, 8'h00, 1'b1, 8'h22);
    req(1'b1, 1'b0, 16'hFF90, 8'h00, 1'b1, 8'h33);
    idle(5);

    // unmapped load
    req(1'b1, 1'b0, 16'hA000, 8'h00, 1'b1, 8'hFF);
    @(negedge clock);
    check("t3_s_load", {60'd0, s_load}, 64'd0);
    check("t3_miss", {63'd0, m_miss}, 64'd1);
    check("t3_miss_count", {56'd0, miss_count}, 64'd1);
    @(negedge clock);
    check("t3_miss_clear", {63'd0, m_miss}, 64'd0);
    idle(4);

    // load+store conflicts
    req(1'b1, 1'b1, 16'hFFFF, 8'h77, 1'b0, 8'h00);
    @(negedge clock);
    check("t4a_s_load", {60'd0, s_load}, 64'd0);
    check("t4a_s_store", {60'd0, s_store}, 64'd0);
    check("t4a_miss", {63'd0, m_miss}, 64'd1);
    check("t4a_miss_count", {56'd0, miss_count}, 64'd2);
    req(1'b1, 1'b1, 16'hDFFF, 8'h77, 1'b0, 8'h00);
    @(negedge clock);
    check("t4b_s_store", {60'd0, s_store}, 64'h4);
    check("t4b_s_load", {60'd0, s_load}, 64'd0);
    check("t4b_s_address", s_address, 64'h0000_1FFF_0000_0000);
    check("t4b_s_indata", {32'd0, s_indata}, 64'h0077_0000);
    check("t4b_miss", {63'd0, m_miss}, 64'd0);
    idle(4);

    // region edges
    req(1'b1, 1'b0, 16'h7FFF, 8'h00, 1'b1, 8'h11);
    @(negedge clock);
    check("t5_7fff_s_load", {60'd0, s_load}, 64'h1);
    check("t5_7fff_s_address", s_address, 64'h0000_0000_0000_7FFF);
    req(1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 8'h5A);
    @(negedge clock);
    check("t5_8000_s_load", {60'd0, s_load}, 64'h2);
    check("t5_8000_s_address", s_address, 64'd0);
    req(1'b1, 1'b0, 16'hFF7F, 8'h00, 1'b1, 8'hFF);
    @(negedge clock);
    check("t5_ff7f_s_load", {60'd0, s_load}, 64'd0);
    check("t5_ff7f_miss", {63'd0, m_miss}, 64'd1);
    check("t5_ff7f_miss_count", {56'd0, miss_count}, 64'd3);
    req(1'b1, 1'b0, 16'hFF80, 8'h00, 1'b1, 8'h33);
    @(negedge clock);
    check("t5_ff80_s_load", {60'd0, s_load}, 64'h8);
    check("t5_ff80_s_address", s_address, 64'd0);
    idle(4);

    // overlapping regions: R0 must win where both R0 and R1 match
    req(1'b1, 1'b0, 16'h0123, 8'h00, 1'b1, 8'h11);
    @(negedge clock);
    check("ovl_0123_s_load", {60'd0, o_load}, 64'h1);
    check("ovl_0123_s_address", o_address, 64'h0000_0000_0000_0123);
    req(1'b1, 1'b0, 16'h8500, 8'h00, 1'b1, 8'h5A);
    @(negedge clock);
    check("ovl_8500_s_load", {60'd0, o_load}, 64'h2);
    check("ovl_8500_s_address", o_address, 64'h0000_0000_8500_0000);
    check("main_8500_s_address", s_address, 64'h0000_0000_0500_0000);
    idle(4);

    // miss_count saturation
    for (int k = 0; k < 300; k++) req(1'b0, 1'b1, 16'hA000, 8'h00, 1'b0, 8'h00);
    @(negedge clock);
    check("t6_miss_count_sat", {56'd0, miss_count}, 64'hFF);
    check("t6_miss", {63'd0, m_miss}, 64'd1);
    @(negedge clock);
    check("t6_miss_count_hold", {56'd0, miss_count}, 64'hFF);
    check("t6_miss_clear", {63'd0, m_miss}, 64'd0);
    idle(4);

    // reset during an in-flight read: no return may follow
    req(1'b1, 1'b0, 16'h8123, 8'h00, 1'b0, 8'h00);
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    idle(6);

    // normal operation after reset
    req(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 8'h11);
    idle(6);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
